rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 15: ROM word-address width, giving a 32K-word instruction space.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum idle cycles allowed between bytes once a load is in progress.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-005 rx_data  input  8  received byte from the serial receiver.
REQ-006 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 reload  input  1  in DONE or ERROR, restarts the load sequence.
REQ-008 rom_addr  output  ADDR_WIDTH  instruction ROM write address.
REQ-009 rom_wdata  output  16  instruction word to write.
REQ-010 rom_we  output  1  ROM write enable, one cycle per word.
REQ-011 cpu_reset  output  1  holds the CPU, and hence its program counter, in reset while loading.
REQ-012 done  output  1  load completed successfully.
REQ-013 error  output  1  load aborted: bad count or timeout.

Function
REQ-014 The stream format SHALL be:
- a 16-bit word count N, high byte first;
- followed by N instruction words, each sent high byte first.
REQ-015 The FSM states SHALL be CNT_HI, CNT_LO, W_HI, W_LO, DONE and ERROR; all outputs SHALL be registered.
REQ-016 In CNT_HI, rx_valid SHALL latch the count high byte and move to CNT_LO.
REQ-017 In CNT_LO, rx_valid SHALL latch the count low byte and transition as follows:
- N=0: go to DONE;
- N > 2^ADDR_WIDTH: go to ERROR;
- otherwise: go to W_HI with the word index cleared to 0.
REQ-018 In W_HI, rx_valid SHALL latch the high byte and move to W_LO.
REQ-019 In W_LO, rx_valid SHALL, on the same edge, drive:
- rom_wdata = {high byte, rx_data};
- rom_addr = word index;
- rom_we = 1.
REQ-020 rom_we SHALL be high for exactly one cycle per word, the cycle after the low-byte strobe, and low at all other times.
REQ-021 The word index SHALL increment after each write.
REQ-022 When the index reaches N after a write, the FSM SHALL enter DONE on the next edge; otherwise it SHALL return to W_HI.
REQ-023 The index SHALL be ADDR_WIDTH+1 bits wide, so that N = 2^ADDR_WIDTH completes without wrap-around; rom_addr SHALL carry only its low ADDR_WIDTH bits.
REQ-024 cpu_reset SHALL be 1 in all states except DONE; it falls on the edge entering DONE, one cycle after the final rom_we pulse.
REQ-025 done SHALL be 1 only in DONE, and error only in ERROR.
REQ-026 Idle timer:
- counts cycles without rx_valid in states CNT_LO, W_HI and W_LO;
- clears on every rx_valid;
- clears on entry to CNT_HI.
REQ-027 When the idle timer reaches TIMEOUT_CYCLES, the FSM SHALL enter ERROR, and no partial word SHALL be written.
REQ-028 CNT_HI SHALL wait indefinitely with no timeout.
REQ-029 In DONE and ERROR, rx_valid SHALL be ignored.
REQ-030 In DONE and ERROR, reload=1 SHALL:
- enter CNT_HI;
- raise cpu_reset on the same edge;
- clear done and error.
REQ-031 In all other states, reload SHALL be ignored.
REQ-032 rx_valid arriving on the same cycle the idle timer expires SHALL win: the byte is accepted and no ERROR occurs.
REQ-033 rom_wdata and rom_addr SHALL hold their last values when rom_we is 0.

Reset
REQ-034 reset SHALL take priority over every other input and act on the next rising edge.
REQ-035 reset SHALL force:
- state = CNT_HI;
- word index, count, and idle timer = 0;
- rom_addr = 0, rom_wdata = 0, rom_we = 0;
- cpu_reset = 1, done = 0, error = 0.
REQ-036 reset asserted mid-load SHALL abandon any partial word without a write, and SHALL cancel a rom_we scheduled for the following cycle.

Verification
REQ-037 Bytes 00 02 12 34 AB CD -> two rom_we pulses: (addr 0, 0x1234) then (addr 1, 0xABCD); cpu_reset falls one cycle after the second pulse; done=1.
REQ-038 Bytes 00 00 -> no rom_we; DONE entered the cycle after the second byte; cpu_reset=0; done=1.
REQ-039 Bytes 80 01 (N=32769 > 32768) -> error=1, cpu_reset stays 1, no rom_we.
REQ-040 With TIMEOUT_CYCLES=8: bytes 00 01 12, then 8 idle cycles -> error=1, no rom_we. Repeat with the byte 34 delivered on the 8th idle cycle -> write of 0x1234 to addr 0, done=1.
REQ-041 reset asserted between the high and low bytes of word 3 -> no further rom_we, cpu_reset=1, state CNT_HI; a fresh stream 00 01 FF FF loads 0xFFFF to addr 0.
REQ-042 From DONE: pulse reload, then bytes 00 01 00 07 -> cpu_reset rises on the reload edge; write of 0x0007 to addr 0; done=1.

Source files
------------

// File: rtl/rom_loader.sv
// ============================================================================
//  Module      : rom_loader
//  Description : Serial boot loader that fills the instruction ROM from a
//                length-prefixed byte stream while holding the CPU in reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_loader #(
  parameter int ADDR_WIDTH     = 15,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  reload,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [15:0]           rom_wdata,
  output logic                  rom_we,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam int          C_IDX_W     = ADDR_WIDTH + 1;
  localparam int          C_TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_TMR_W-1:0] C_TIMEOUT = C_TMR_W'(TIMEOUT_CYCLES);
  localparam logic [31:0] C_MAX_WORDS = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    CNT_HI = 3'd0,
    CNT_LO = 3'd1,
    W_HI   = 3'd2,
    W_LO   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t               r_state;
  logic [15:0]          r_count;
  logic [C_IDX_W-1:0]   r_idx;
  logic [7:0]           r_hi;
  logic [C_TMR_W-1:0]   r_tmr;
  logic                 r_fin;

  state_t               w_state_nxt;
  logic [15:0]          w_count_nxt;
  logic [C_IDX_W-1:0]   w_idx_nxt;
  logic [7:0]           w_hi_nxt;
  logic [C_TMR_W-1:0]   w_tmr_nxt;
  logic                 w_fin_nxt;
  logic                 w_we_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [15:0]          w_wdata_nxt;

  logic [15:0]          w_n;
  logic [C_TMR_W-1:0]   w_tmr_inc;
  logic                 w_timeout;
  logic [31:0]          w_idx_inc32;

  assign w_n         = {r_count[15:8], rx_data};
  assign w_tmr_inc   = r_tmr + 1'b1;
  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign w_timeout   = !rx_valid && (w_tmr_inc == C_TIMEOUT);
  assign w_idx_inc32 = 32'(r_idx) + 32'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_idx_nxt   = r_idx;
    w_hi_nxt    = r_hi;
    w_tmr_nxt   = rx_valid ? '0 : w_tmr_inc;
    w_fin_nxt   = r_fin;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = rom_addr;
    w_wdata_nxt = rom_wdata;

    case (r_state)
      CNT_HI: begin
        w_tmr_nxt = '0;
        if (rx_valid) begin
          w_count_nxt[15:8] = rx_data;
          w_state_nxt       = CNT_LO;
        end
      end
      CNT_LO: begin
        if (rx_valid) begin
          w_count_nxt = w_n;
          if (w_n == 16'd0) begin
            w_state_nxt = DONE;
          end else if ({16'd0, w_n} > C_MAX_WORDS) begin
            w_state_nxt = ERROR;
          end else begin
            w_idx_nxt   = '0;
            w_state_nxt = W_HI;
          end
        end else if (w_timeout) begin
          w_state_nxt = ERROR;
        end
      end
      W_HI: begin
        if (rx_valid) begin
          w_hi_nxt    = rx_data;
          w_state_nxt = W_LO;
        end else if (w_timeout) begin
          w_state_nxt = ERROR;
        end
      end
      W_LO: begin
        // r_fin marks the cycle the final write is on the bus; DONE follows it.
        if (r_fin) begin
          w_fin_nxt   = 1'b0;
          w_state_nxt = DONE;
        end else if (rx_valid) begin
          w_we_nxt    = 1'b1;
          w_wdata_nxt = {r_hi, rx_data};
          w_addr_nxt  = r_idx[ADDR_WIDTH-1:0];
          w_idx_nxt   = r_idx + 1'b1;
          if (w_idx_inc32 == {16'd0, r_count}) begin
            w_fin_nxt = 1'b1;
          end else begin
            w_state_nxt = W_HI;
          end
        end else if (w_timeout) begin
          w_state_nxt = ERROR;
        end
      end
      DONE, ERROR: begin
        w_tmr_nxt = '0;
        if (reload) begin
          w_state_nxt = CNT_HI;
        end
      end
      default: begin
        w_state_nxt = CNT_HI;
        w_tmr_nxt   = '0;
        w_fin_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CNT_HI;
      r_count   <= '0;
      r_idx     <= '0;
      r_hi      <= '0;
      r_tmr     <= '0;
      r_fin     <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      rom_we    <= 1'b0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_idx     <= w_idx_nxt;
      r_hi      <= w_hi_nxt;
      r_tmr     <= w_tmr_nxt;
      r_fin     <= w_fin_nxt;
      rom_addr  <= w_addr_nxt;
      rom_wdata <= w_wdata_nxt;
      rom_we    <= w_we_nxt;
      cpu_reset <= (w_state_nxt != DONE);
      done      <= (w_state_nxt == DONE);
      error     <= (w_state_nxt == ERROR);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
// ============================================================================
//  Module      : tb_rom_loader
//  Description : Directed self-checking bench for rom_loader (TIMEOUT_CYCLES=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        reload;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        rom_we;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [14:0] q_addr[$];
  logic [15:0] q_data[$];

  rom_loader #(.ADDR_WIDTH(15), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .reload(reload), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .rom_we(rom_we), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every observed ROM write is logged for later comparison.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      q_addr.push_back(rom_addr);
      q_data.push_back(rom_wdata);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_b(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic clear_log();
    #1;
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rom_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rom_we); end
    checks++; if (rom_addr !== 15'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", rom_addr); end
    checks++; if (rom_wdata !== 16'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", rom_wdata); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    reset = 1'b0;
    // CNT_HI has no timeout: idle well past TIMEOUT_CYCLES.
    repeat (20) @(negedge clk);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL cnt_hi_no_timeout: error got %b want 0", error); end
    clear_log();
  endtask

  task automatic test_two_words();
    send_b(8'h00); send_b(8'h02); send_b(8'h12); send_b(8'h34); send_b(8'hAB); send_b(8'hCD);
    checks++; if (rom_we !== 1'b1) begin errors++; $display("FAIL two_words_we: got %b want 1", rom_we); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL two_words_cpu_reset_held: got %b want 1", cpu_reset); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL two_words_done_early: got %b want 0", done); end
    @(negedge clk);
    checks++; if (rom_we !== 1'b0) begin errors++; $display("FAIL two_words_we_low: got %b want 0", rom_we); end
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL two_words_cpu_reset_fall: got %b want 0", cpu_reset); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL two_words_done: got %b want 1", done); end
    #1;
    checks++; if (q_addr.size() !== 2) begin errors++; $display("FAIL two_words_count: got %0d writes want 2", q_addr.size()); end
    else begin
      checks++; if (q_addr[0] !== 15'd0 || q_data[0] !== 16'h1234) begin errors++; $display("FAIL two_words_w0: got %h/%h want 0000/1234", q_addr[0], q_data[0]); end
      checks++; if (q_addr[1] !== 15'd1 || q_data[1] !== 16'hABCD) begin errors++; $display("FAIL two_words_w1: got %h/%h want 0001/abcd", q_addr[1], q_data[1]); end
    end
    clear_log();
  endtask

  task automatic test_ignore_rx_in_done();
    send_b(8'h00); send_b(8'h01); send_b(8'h55); send_b(8'h66);
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL done_ignores_rx: done/cpu_reset got %b/%b want 1/0", done, cpu_reset); end
    #1;
    checks++; if (q_addr.size() !== 0) begin errors++; $display("FAIL done_ignores_rx_writes: got %0d want 0", q_addr.size()); end
    clear_log();
  endtask

  task automatic test_reload();
    pulse_reload();
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reload_cpu_reset: got %b want 1", cpu_reset); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reload_done_clear: got %b want 0", done); end
    send_b(8'h00); send_b(8'h01); send_b(8'h00); send_b(8'h07);
    checks++; if (rom_we !== 1'b1 || rom_addr !== 15'd0 || rom_wdata !== 16'h0007) begin
      errors++; $display("FAIL reload_write: got we=%b addr=%h data=%h want 1/0000/0007", rom_we, rom_addr, rom_wdata); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL reload_done: done/cpu_reset got %b/%b want 1/0", done, cpu_reset); end
    repeat (3) @(negedge clk);
    checks++; if (rom_addr !== 15'd0 || rom_wdata !== 16'h0007) begin errors++; $display("FAIL reload_hold: got %h/%h want 0000/0007", rom_addr, rom_wdata); end
    clear_log();
  endtask

  task automatic test_zero_count();
    pulse_reload();
    send_b(8'h00); send_b(8'h00);
    checks++; if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL zero_count: done/cpu_reset/error got %b/%b/%b want 1/0/0", done, cpu_reset, error); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (q_addr.size() !== 0) begin errors++; $display("FAIL zero_count_writes: got %0d want 0", q_addr.size()); end
    clear_log();
  endtask

  task automatic test_bad_count();
    pulse_reload();
    send_b(8'h80); send_b(8'h01);
    checks++; if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL bad_count: error/cpu_reset/done got %b/%b/%b want 1/1/0", error, cpu_reset, done); end
    // N = 2^ADDR_WIDTH exactly is legal.
    pulse_reload();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reload_error_clear: got %b want 0", error); end
    send_b(8'h80); send_b(8'h00);
    checks++; if (error !== 1'b0 || cpu_reset !== 1'b1) begin errors++; $display("FAIL max_count_ok: error/cpu_reset got %b/%b want 0/1", error, cpu_reset); end
    // reload is ignored while a load is in progress.
    pulse_reload();
    send_b(8'h12); send_b(8'h34);
    checks++; if (rom_we !== 1'b1 || rom_wdata !== 16'h1234 || rom_addr !== 15'd0) begin
      errors++; $display("FAIL reload_ignored_midload: got we=%b addr=%h data=%h want 1/0000/1234", rom_we, rom_addr, rom_wdata); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_log();
  endtask

  task automatic test_timeout();
    send_b(8'h00); send_b(8'h01); send_b(8'h12);
    repeat (7) @(negedge clk);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_early: error got %b want 0 after 7 idle", error); end
    @(negedge clk);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_fire: error got %b want 1 after 8 idle", error); end
    #1;
    checks++; if (q_addr.size() !== 0) begin errors++; $display("FAIL timeout_no_write: got %0d want 0", q_addr.size()); end
    pulse_reload();
    send_b(8'h00); send_b(8'h01); send_b(8'h12);
    repeat (6) @(negedge clk);
    send_b(8'h34);
    checks++; if (rom_we !== 1'b1 || rom_wdata !== 16'h1234 || rom_addr !== 15'd0 || error !== 1'b0) begin
      errors++; $display("FAIL timeout_race: got we=%b addr=%h data=%h err=%b want 1/0000/1234/0", rom_we, rom_addr, rom_wdata, error); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL timeout_race_done: got %b want 1", done); end
    clear_log();
  endtask

  task automatic test_reset_mid_load();
    pulse_reload();
    send_b(8'h00); send_b(8'h05);
    send_b(8'h01); send_b(8'h01); send_b(8'h02); send_b(8'h02); send_b(8'h03); send_b(8'h03);
    send_b(8'h04);
    @(negedge clk);
    reset    = 1'b1;
    rx_data  = 8'h44;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++; if (rom_we !== 1'b0) begin errors++; $display("FAIL midload_we_cancel: got %b want 0", rom_we); end
    @(negedge clk);
    reset = 1'b0;
    checks++; if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL midload_state: cpu_reset/done/error got %b/%b/%b want 1/0/0", cpu_reset, done, error); end
    #1;
    checks++; if (q_addr.size() !== 3) begin errors++; $display("FAIL midload_writes: got %0d want 3", q_addr.size()); end
    else begin
      checks++; if (q_addr[2] !== 15'd2 || q_data[2] !== 16'h0303) begin errors++; $display("FAIL midload_w2: got %h/%h want 0002/0303", q_addr[2], q_data[2]); end
    end
    clear_log();
    send_b(8'h00); send_b(8'h01); send_b(8'hFF); send_b(8'hFF);
    @(negedge clk);
    checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL fresh_done: done/cpu_reset got %b/%b want 1/0", done, cpu_reset); end
    #1;
    checks++; if (q_addr.size() !== 1) begin errors++; $display("FAIL fresh_writes: got %0d want 1", q_addr.size()); end
    else begin
      checks++; if (q_addr[0] !== 15'd0 || q_data[0] !== 16'hFFFF) begin errors++; $display("FAIL fresh_w0: got %h/%h want 0000/ffff", q_addr[0], q_data[0]); end
    end
    clear_log();
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    reload   = 1'b0;
    test_reset();
    test_two_words();
    test_ignore_rx_in_done();
    test_reload();
    test_zero_count();
    test_bad_count();
    test_timeout();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
